inference_scheduler: RTL and testbench
======================================

Name: inference_scheduler

Overview:
- Sequences one inference on the feature-classifier matrix-multiply engine: schedules a run, streams the feature vector from the binning readout RAM into the engine, collects scores, and emits a debounced gesture decision.
- Sits between the time-surface binning memory and the matrix-multiply engine; drives the engine's start and feature stream, and consumes its result bus.

Parameters:
- NUM_CELLS, 1280, feature vector length (bins × grid cells).
- NUM_CLASSES, 4, class count; fixed at 4 by the 2-bit class fields.
- VALUE_BITS, 8, feature width.
- ACC_BITS, 24, signed score width.
- PERIOD_BITS, 24, width of the runtime inference period.
- TIMEOUT_CYCLES, 64, maximum wait for a result after the stream ends.
- CONFIRM_COUNT, 2, number of consecutive identical accepted candidates before a gesture is reported (≥1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  periodic scheduling enable
- period_cycles  in  PERIOD_BITS  cycles between periodic triggers (0 or 1 treated as 2)
- trigger  in  1  manual one-shot inference request
- min_score  in  ACC_BITS  signed minimum winning score
- min_margin  in  ACC_BITS  unsigned minimum (best − second best)
- feat_rd_en  out  1  feature RAM read strobe
- feat_rd_addr  out  $clog2(NUM_CELLS)  feature RAM address
- feat_rd_data  in  VALUE_BITS  feature RAM data, valid 1 cycle after feat_rd_en
- mm_start  out  1  engine start pulse
- mm_feature  out  VALUE_BITS  feature stream to engine
- mm_feature_valid  out  1  feature qualifier
- mm_result_valid  in  1  engine result strobe
- mm_best_class  in  2  engine argmax
- mm_scores_flat  in  NUM_CLASSES*ACC_BITS  engine scores, class k at bits [(k+1)*ACC_BITS-1 : k*ACC_BITS]
- busy  out  1  inference in progress
- gesture_valid  out  1  one-cycle decision pulse
- gesture_class  out  2  reported class
- gesture_margin  out  ACC_BITS  margin of the reported decision
- timeout_err  out  1  one-cycle pulse on result timeout
- overrun_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset: all outputs 0; state S_IDLE; period counter 0; pending 0; streak 0; last candidate 0.
- Period counter: increments while enable=1 and wraps at period_cycles−1, generating a tick. When enable=0 it holds at 0 and pending is cleared; a run in progress still completes.
- Pending request: set by a tick or by trigger. A request that arrives while pending is already 1 sets overrun_err. A request coincident with entry to S_IDLE is not lost.
- S_IDLE: when pending=1, clear pending and go to S_STREAM.
  - In the same cycle T: assert mm_start=1 (one cycle), feat_rd_en=1, feat_rd_addr=0.
- S_STREAM: issue reads at addresses 0..NUM_CELLS−1 on consecutive cycles T..T+NUM_CELLS−1.
  - mm_feature_valid is feat_rd_en delayed one cycle; mm_feature = feat_rd_data.
  - Result: exactly NUM_CELLS contiguous valid beats, on cycles T+1..T+NUM_CELLS.
  - After the last read, go to S_WAIT.
- S_WAIT: a counter runs from the final valid beat.
  - On mm_result_valid: latch the scores and mm_best_class, then go to S_DECIDE.
  - If the counter reaches TIMEOUT_CYCLES first: pulse timeout_err, reset streak to 0, and return to S_IDLE.
  - mm_result_valid outside S_WAIT is ignored.
- S_DECIDE (1 cycle):
  - best = score[mm_best_class]; second = maximum of the other three scores, signed.
  - margin = best − second, computed in ACC_BITS+1 bits and saturated to ACC_BITS.
  - The result is accepted if best ≥ min_score (signed) and margin ≥ min_margin.
  - If accepted and class == last candidate: streak++ (saturating at CONFIRM_COUNT). If accepted and a different class: last candidate = class, streak = 1. If rejected: streak = 0.
  - When streak reaches CONFIRM_COUNT on this cycle: pulse gesture_valid for one cycle with gesture_class and gesture_margin. Those two outputs hold until the next pulse.
  - A repeated gesture re-reports on every confirmed run after the first.
  - Return to S_IDLE.
- busy = 1 in every state except S_IDLE.
- Minimum inference latency from the pending request to gesture_valid is NUM_CELLS + engine latency + 2 cycles.
- rst_n low mid-stream: synchronous abort on the next edge, with no further mm_feature_valid beats.

Test Plan:
- Basic run: NUM_CELLS=16; pulse trigger.
  - mm_start occurs at T.
  - Reads at addresses 0..15 on T..T+15.
  - mm_feature_valid is high on exactly T+1..T+16 and carries the RAM data in order.
- Decision with CONFIRM_COUNT=2, min_score=0, min_margin=10.
  - Two runs returning scores {5,40,20,−3}, best=1 → gesture_valid on the second run only, class 1, margin 20.
  - A third run with scores {5,25,20,0} (margin 5) → rejected, streak=0, no pulse.
- Class switch: runs with best = 2, then 3, then 3 → a single gesture_valid on the third run, class 3.
- Timeout: TIMEOUT_CYCLES=64, mm_result_valid never asserted.
  - timeout_err pulses 64 cycles after the last beat; busy drops the next cycle.
  - A late mm_result_valid produces no gesture_valid.
- Periodic scheduling: period_cycles=100, NUM_CELLS=1280.
  - The second tick is pending during the run.
  - The third tick arrives while pending → overrun_err=1 and stays high.
  - Exactly two runs start.
  - enable=0 clears pending.
- Reset mid-stream: rst_n low at address 7 for one cycle → all outputs 0 the next cycle and no further reads. A trigger after reset starts a clean run from address 0.

Source files
------------

// File: rtl/inference_scheduler.sv
// inference_scheduler: sequences one classifier inference at a time.
//   - Periodic or manual requests are held in a single pending slot.
//   - A run pulses mm_start, reads feature RAM addresses 0..NUM_CELLS-1 and
//     forwards the read data to the engine as a contiguous valid stream.
//   - It then waits (bounded) for the engine result, scores the winner against
//     min_score/min_margin and debounces the class over CONFIRM_COUNT runs.
// Ports:
//   clk, rst_n (synchronous, active-low)
//   enable, period_cycles, trigger           request sources
//   min_score, min_margin                    acceptance thresholds
//   feat_rd_en/addr/data                     feature RAM read port (1-cycle latency)
//   mm_start, mm_feature, mm_feature_valid   engine control and stream
//   mm_result_valid, mm_best_class, mm_scores_flat  engine result
//   busy, gesture_valid/class/margin         status and decision
//   timeout_err (pulse), overrun_err (sticky)
module inference_scheduler #(
  parameter int unsigned NUM_CELLS      = 1280,
  parameter int unsigned NUM_CLASSES    = 4,
  parameter int unsigned VALUE_BITS     = 8,
  parameter int unsigned ACC_BITS       = 24,
  parameter int unsigned PERIOD_BITS    = 24,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CONFIRM_COUNT  = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [PERIOD_BITS-1:0]          period_cycles,
  input  logic                            trigger,
  input  logic [ACC_BITS-1:0]             min_score,
  input  logic [ACC_BITS-1:0]             min_margin,
  output logic                            feat_rd_en,
  output logic [$clog2(NUM_CELLS)-1:0]    feat_rd_addr,
  input  logic [VALUE_BITS-1:0]           feat_rd_data,
  output logic                            mm_start,
  output logic [VALUE_BITS-1:0]           mm_feature,
  output logic                            mm_feature_valid,
  input  logic                            mm_result_valid,
  input  logic [1:0]                      mm_best_class,
  input  logic [NUM_CLASSES*ACC_BITS-1:0] mm_scores_flat,
  output logic                            busy,
  output logic                            gesture_valid,
  output logic [1:0]                      gesture_class,
  output logic [ACC_BITS-1:0]             gesture_margin,
  output logic                            timeout_err,
  output logic                            overrun_err
);

  localparam int unsigned ADDR_BITS   = $clog2(NUM_CELLS);
  localparam int unsigned WAIT_BITS   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned STREAK_BITS = $clog2(CONFIRM_COUNT + 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_DECIDE} state_t;

  state_t                                state, state_n;
  logic [PERIOD_BITS-1:0]                period_cnt, period_cnt_n, eff_period;
  logic                                  tick, req, take;
  logic                                  pending, pending_n, enable_q, overrun_n;
  logic [ADDR_BITS-1:0]                  rd_addr_n;
  logic                                  rd_en_n, start_n;
  logic [WAIT_BITS-1:0]                  wait_cnt, wait_cnt_n;
  logic [NUM_CLASSES-1:0][ACC_BITS-1:0]  scores_q, scores_n, scores_in;
  logic [1:0]                            cls_q, cls_n, last_cls, last_cls_n;
  logic [STREAK_BITS-1:0]                streak, streak_n;
  logic                                  gv_n, to_n;
  logic [1:0]                            gc_n;
  logic [ACC_BITS-1:0]                   gm_n;
  logic [ACC_BITS-1:0]                   best, second, margin;
  logic [ACC_BITS:0]                     diff;
  logic                                  accept;

  assign scores_in = mm_scores_flat;

  // Feature data passes straight through; gating keeps it 0 outside valid beats.
  assign mm_feature = mm_feature_valid ? feat_rd_data : '0;

  // Period tick and pending-request bookkeeping.
  always_comb begin
    eff_period   = (period_cycles < PERIOD_BITS'(2)) ? PERIOD_BITS'(2) : period_cycles;
    tick         = enable && (period_cnt >= eff_period - PERIOD_BITS'(1));
    period_cnt_n = '0;
    if (enable && !tick) period_cnt_n = period_cnt + PERIOD_BITS'(1);
    req  = tick || trigger;
    take = (state == S_IDLE) && pending;
    pending_n = pending;
    // Only the falling edge of enable flushes pending, so a manual trigger
    // issued while enable is low is not discarded.
    if (take || (enable_q && !enable)) pending_n = 1'b0;
    if (req) pending_n = 1'b1;
    // A request landing on the cycle the old one is consumed simply refills the slot.
    overrun_n = overrun_err || (req && pending && !take);
  end

  // Winner/runner-up margin and acceptance test on the latched scores.
  always_comb begin
    best   = scores_q[cls_q];
    second = {1'b1, {(ACC_BITS-1){1'b0}}};
    for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
      if ((2'(k) != cls_q) && ($signed(scores_q[2'(k)]) > $signed(second)))
        second = scores_q[2'(k)];
    end
    diff = {best[ACC_BITS-1], best} - {second[ACC_BITS-1], second};
    // Positive differences always fit; only a negative one (engine argmax
    // disagreeing with the scores) needs clamping.
    margin = diff[ACC_BITS] ? '0 : diff[ACC_BITS-1:0];
    accept = ($signed(best) >= $signed(min_score)) && (margin >= min_margin);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n    = state;
    rd_en_n    = 1'b0;
    rd_addr_n  = feat_rd_addr;
    start_n    = 1'b0;
    wait_cnt_n = wait_cnt;
    scores_n   = scores_q;
    cls_n      = cls_q;
    last_cls_n = last_cls;
    streak_n   = streak;
    gv_n       = 1'b0;
    gc_n       = gesture_class;
    gm_n       = gesture_margin;
    to_n       = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending) begin
          state_n   = S_STREAM;
          start_n   = 1'b1;
          rd_en_n   = 1'b1;
          rd_addr_n = '0;
        end
      end
      S_STREAM: begin
        if (feat_rd_addr == ADDR_BITS'(NUM_CELLS - 1)) begin
          state_n    = S_WAIT;
          rd_addr_n  = '0;
          wait_cnt_n = '0;
        end else begin
          rd_en_n   = 1'b1;
          rd_addr_n = feat_rd_addr + ADDR_BITS'(1);
        end
      end
      S_WAIT: begin
        if (mm_result_valid && (wait_cnt != WAIT_BITS'(TIMEOUT_CYCLES))) begin
          scores_n = scores_in;
          cls_n    = mm_best_class;
          state_n  = S_DECIDE;
        end else if (wait_cnt == WAIT_BITS'(TIMEOUT_CYCLES)) begin
          state_n = S_IDLE;
        end else begin
          wait_cnt_n = wait_cnt + WAIT_BITS'(1);
          // Pulse lands on the cycle the count reaches the limit, while still busy.
          if (wait_cnt == WAIT_BITS'(TIMEOUT_CYCLES - 1)) begin
            to_n     = 1'b1;
            streak_n = '0;
          end
        end
      end
      S_DECIDE: begin
        state_n = S_IDLE;
        if (accept) begin
          if (cls_q == last_cls) begin
            streak_n = (streak >= STREAK_BITS'(CONFIRM_COUNT)) ?
                       STREAK_BITS'(CONFIRM_COUNT) : streak + STREAK_BITS'(1);
          end else begin
            last_cls_n = cls_q;
            streak_n   = STREAK_BITS'(1);
          end
          if (streak_n == STREAK_BITS'(CONFIRM_COUNT)) begin
            gv_n = 1'b1;
            gc_n = cls_q;
            gm_n = margin;
          end
        end else begin
          streak_n = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      period_cnt       <= '0;
      pending          <= 1'b0;
      enable_q         <= 1'b0;
      feat_rd_en       <= 1'b0;
      feat_rd_addr     <= '0;
      mm_start         <= 1'b0;
      mm_feature_valid <= 1'b0;
      wait_cnt         <= '0;
      scores_q         <= '0;
      cls_q            <= '0;
      last_cls         <= '0;
      streak           <= '0;
      busy             <= 1'b0;
      gesture_valid    <= 1'b0;
      gesture_class    <= '0;
      gesture_margin   <= '0;
      timeout_err      <= 1'b0;
      overrun_err      <= 1'b0;
    end else begin
      state            <= state_n;
      period_cnt       <= period_cnt_n;
      pending          <= pending_n;
      enable_q         <= enable;
      feat_rd_en       <= rd_en_n;
      feat_rd_addr     <= rd_addr_n;
      mm_start         <= start_n;
      mm_feature_valid <= feat_rd_en;
      wait_cnt         <= wait_cnt_n;
      scores_q         <= scores_n;
      cls_q            <= cls_n;
      last_cls         <= last_cls_n;
      streak           <= streak_n;
      busy             <= (state_n != S_IDLE);
      gesture_valid    <= gv_n;
      gesture_class    <= gc_n;
      gesture_margin   <= gm_n;
      timeout_err      <= to_n;
      overrun_err      <= overrun_n;
    end
  end

endmodule

// File: tb/tb_inference_scheduler.sv
// tb_inference_scheduler: directed tests for inference_scheduler with a
// 16-cell feature RAM model and a hand-driven engine result port.
module tb_inference_scheduler;

  localparam int unsigned NUM_CELLS = 16;
  localparam int unsigned ACC_BITS  = 24;
  localparam int unsigned TIMEOUT   = 64;
  localparam int unsigned OUT_W     = 1 + 4 + 1 + 8 + 1 + 1 + 1 + 2 + 24 + 1 + 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  enable;
  logic [23:0]           period_cycles;
  logic                  trigger;
  logic [ACC_BITS-1:0]   min_score, min_margin;
  logic                  feat_rd_en;
  logic [3:0]            feat_rd_addr;
  logic [7:0]            feat_rd_data;
  logic                  mm_start;
  logic [7:0]            mm_feature;
  logic                  mm_feature_valid;
  logic                  mm_result_valid;
  logic [1:0]            mm_best_class;
  logic [4*ACC_BITS-1:0] mm_scores_flat;
  logic                  busy, gesture_valid, timeout_err, overrun_err;
  logic [1:0]            gesture_class;
  logic [ACC_BITS-1:0]   gesture_margin;
  logic [OUT_W-1:0]      all_out;

  logic [7:0] mem [0:NUM_CELLS-1];
  int n_tests = 0;
  int n_fail  = 0;

  inference_scheduler #(
    .NUM_CELLS(NUM_CELLS), .NUM_CLASSES(4), .VALUE_BITS(8), .ACC_BITS(ACC_BITS),
    .PERIOD_BITS(24), .TIMEOUT_CYCLES(TIMEOUT), .CONFIRM_COUNT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period_cycles(period_cycles),
    .trigger(trigger), .min_score(min_score), .min_margin(min_margin),
    .feat_rd_en(feat_rd_en), .feat_rd_addr(feat_rd_addr), .feat_rd_data(feat_rd_data),
    .mm_start(mm_start), .mm_feature(mm_feature), .mm_feature_valid(mm_feature_valid),
    .mm_result_valid(mm_result_valid), .mm_best_class(mm_best_class),
    .mm_scores_flat(mm_scores_flat), .busy(busy), .gesture_valid(gesture_valid),
    .gesture_class(gesture_class), .gesture_margin(gesture_margin),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  // Feature RAM with one-cycle read latency.
  always @(posedge clk) if (feat_rd_en) feat_rd_data <= mem[feat_rd_addr];

  assign all_out = {feat_rd_en, feat_rd_addr, mm_start, mm_feature, mm_feature_valid, busy,
                    gesture_valid, gesture_class, gesture_margin, timeout_err, overrun_err};

  function automatic logic [4*ACC_BITS-1:0] pack4(input int s0, input int s1,
                                                  input int s2, input int s3);
    return {24'(s3), 24'(s2), 24'(s1), 24'(s0)};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse trigger and return at the negedge where mm_start is visible.
  task automatic fire(output bit found);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mm_start === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One full run answered by the engine; reports gesture pulses seen.
  task automatic run(input logic [4*ACC_BITS-1:0] sc, input logic [1:0] cls,
                     output bit found, output int pulses,
                     output logic [1:0] g_cls, output logic [ACC_BITS-1:0] g_mar);
    pulses = 0;
    g_cls  = '0;
    g_mar  = '0;
    fire(found);
    if (!found) return;
    cycles(NUM_CELLS + 3);
    mm_scores_flat  = sc;
    mm_best_class   = cls;
    mm_result_valid = 1'b1;
    @(negedge clk);
    mm_result_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (gesture_valid === 1'b1) begin
        pulses++;
        g_cls = gesture_class;
        g_mar = gesture_margin;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycles(3);
    n_tests++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    rst_n = 1'b1;
    cycles(2);
    n_tests++;
    if (busy !== 1'b0 || feat_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b rd_en=%b expected 0 0", busy, feat_rd_en);
    end
  endtask

  task automatic test_basic_run();
    bit found;
    bit exp_en, exp_v;
    int bad;
    fire(found);
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL basic_start: mm_start not seen, expected within 8 cycles");
      return;
    end
    bad = 0;
    for (int k = 0; k <= NUM_CELLS + 1; k++) begin
      exp_en = (k < NUM_CELLS);
      exp_v  = (k >= 1) && (k <= NUM_CELLS);
      n_tests++;
      if (feat_rd_en !== exp_en || (exp_en && feat_rd_addr !== 4'(k))) begin
        n_fail++;
        $display("FAIL basic_read k=%0d: en=%b addr=%0d expected en=%b addr=%0d",
                 k, feat_rd_en, feat_rd_addr, exp_en, k);
      end
      n_tests++;
      if (mm_feature_valid !== exp_v || (exp_v && mm_feature !== mem[k-1])) begin
        n_fail++;
        $display("FAIL basic_stream k=%0d: valid=%b data=%h expected valid=%b",
                 k, mm_feature_valid, mm_feature, exp_v);
      end
      n_tests++;
      if (mm_start !== (k == 0) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_start_busy k=%0d: start=%b busy=%b expected start=%b busy=1",
                 k, mm_start, busy, (k == 0));
      end
      @(negedge clk);
    end
    // No result is given: let the run time out before the next test.
    for (int i = 0; i < 200 && busy === 1'b1; i++) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_decision();
    bit found;
    int p;
    logic [1:0] c;
    logic [ACC_BITS-1:0] m;
    min_score  = 24'd0;
    min_margin = 24'd10;
    run(pack4(5, 40, 20, -3), 2'd1, found, p, c, m);
    n_tests++;
    if (!found || p != 0) begin
      n_fail++;
      $display("FAIL decision_first: found=%0d pulses=%0d expected found=1 pulses=0", found, p);
    end
    run(pack4(5, 40, 20, -3), 2'd1, found, p, c, m);
    n_tests++;
    if (!found || p != 1 || c !== 2'd1 || m !== 24'd20) begin
      n_fail++;
      $display("FAIL decision_confirm: found=%0d pulses=%0d class=%0d margin=%0d expected 1 1 1 20",
               found, p, c, m);
    end
    run(pack4(5, 25, 20, 0), 2'd1, found, p, c, m);
    n_tests++;
    if (!found || p != 0) begin
      n_fail++;
      $display("FAIL decision_reject: found=%0d pulses=%0d expected found=1 pulses=0", found, p);
    end
    n_tests++;
    if (gesture_class !== 2'd1 || gesture_margin !== 24'd20) begin
      n_fail++;
      $display("FAIL decision_hold: class=%0d margin=%0d expected 1 20", gesture_class, gesture_margin);
    end
  endtask

  // Thresholds met exactly (best == min_score, margin == min_margin).
  task automatic test_class_switch();
    bit found;
    int p;
    logic [1:0] c;
    logic [ACC_BITS-1:0] m;
    min_score  = 24'd30;
    min_margin = 24'd10;
    run(pack4(20, 0, 30, -5), 2'd2, found, p, c, m);
    n_tests++;
    if (!found || p != 0) begin
      n_fail++;
      $display("FAIL switch_c2: found=%0d pulses=%0d expected 1 0", found, p);
    end
    run(pack4(20, 0, -100, 30), 2'd3, found, p, c, m);
    n_tests++;
    if (!found || p != 0) begin
      n_fail++;
      $display("FAIL switch_c3a: found=%0d pulses=%0d expected 1 0", found, p);
    end
    run(pack4(20, 0, -100, 30), 2'd3, found, p, c, m);
    n_tests++;
    if (!found || p != 1 || c !== 2'd3 || m !== 24'd10) begin
      n_fail++;
      $display("FAIL switch_c3b: found=%0d pulses=%0d class=%0d margin=%0d expected 1 1 3 10",
               found, p, c, m);
    end
  endtask

  task automatic test_timeout();
    bit found;
    int late;
    fire(found);
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL timeout_start: mm_start not seen, expected within 8 cycles");
      return;
    end
    for (int k = 0; k <= NUM_CELLS + TIMEOUT + 2; k++) begin
      n_tests++;
      if (timeout_err !== (k == NUM_CELLS + TIMEOUT)) begin
        n_fail++;
        $display("FAIL timeout_pulse k=%0d: got %b expected %b", k, timeout_err,
                 (k == NUM_CELLS + TIMEOUT));
      end
      if (k == NUM_CELLS + TIMEOUT || k == NUM_CELLS + TIMEOUT + 1) begin
        n_tests++;
        if (busy !== (k == NUM_CELLS + TIMEOUT)) begin
          n_fail++;
          $display("FAIL timeout_busy k=%0d: got %b expected %b", k, busy,
                   (k == NUM_CELLS + TIMEOUT));
        end
      end
      @(negedge clk);
    end
    mm_scores_flat  = pack4(20, 0, -100, 30);
    mm_best_class   = 2'd3;
    mm_result_valid = 1'b1;
    @(negedge clk);
    mm_result_valid = 1'b0;
    late = 0;
    for (int j = 0; j < 8; j++) begin
      if (gesture_valid === 1'b1) late++;
      @(negedge clk);
    end
    n_tests++;
    if (late != 0) begin
      n_fail++;
      $display("FAIL timeout_late_result: pulses=%0d expected 0", late);
    end
  endtask

  // Timeout cleared the streak; confirmation restarts, then repeats re-report.
  task automatic test_back_to_back();
    bit found;
    int p;
    logic [1:0] c;
    logic [ACC_BITS-1:0] m;
    run(pack4(20, 0, -100, 30), 2'd3, found, p, c, m);
    n_tests++;
    if (!found || p != 0) begin
      n_fail++;
      $display("FAIL b2b_after_timeout: found=%0d pulses=%0d expected 1 0", found, p);
    end
    for (int r = 0; r < 2; r++) begin
      run(pack4(20, 0, -100, 30), 2'd3, found, p, c, m);
      n_tests++;
      if (!found || p != 1 || c !== 2'd3 || m !== 24'd10) begin
        n_fail++;
        $display("FAIL b2b_report%0d: found=%0d pulses=%0d class=%0d margin=%0d expected 1 1 3 10",
                 r, found, p, c, m);
      end
    end
  endtask

  task automatic test_periodic();
    int starts;
    bit found;
    period_cycles = 24'd10;
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mm_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!found || overrun_err !== 1'b0) begin
      n_fail++;
      $display("FAIL periodic_first: found=%0d overrun=%b expected 1 0", found, overrun_err);
      enable = 1'b0;
      return;
    end
    starts = 1;
    for (int i = 1; i < 300; i++) begin
      @(negedge clk);
      if (mm_start === 1'b1) begin
        starts++;
        if (starts == 2) enable = 1'b0;
      end
      if (i == 25) begin
        n_tests++;
        if (overrun_err !== 1'b1) begin
          n_fail++;
          $display("FAIL periodic_overrun: got %b expected 1", overrun_err);
        end
      end
    end
    n_tests++;
    if (starts != 2) begin
      n_fail++;
      $display("FAIL periodic_runs: got %0d starts expected 2", starts);
    end
    n_tests++;
    if (overrun_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL periodic_sticky: overrun=%b busy=%b expected 1 0", overrun_err, busy);
    end
  endtask

  task automatic test_reset_mid_stream();
    bit found;
    int stray;
    fire(found);
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL rstmid_start: mm_start not seen, expected within 8 cycles");
      return;
    end
    cycles(7);
    n_tests++;
    if (feat_rd_addr !== 4'd7) begin
      n_fail++;
      $display("FAIL rstmid_addr: got %0d expected 7", feat_rd_addr);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %h expected 0", all_out);
    end
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (feat_rd_en !== 1'b0 || mm_feature_valid !== 1'b0) stray++;
    end
    n_tests++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: %0d active cycles expected 0", stray);
    end
    fire(found);
    n_tests++;
    if (!found || feat_rd_en !== 1'b1 || feat_rd_addr !== 4'd0) begin
      n_fail++;
      $display("FAIL rstmid_restart: found=%0d en=%b addr=%0d expected 1 1 0",
               found, feat_rd_en, feat_rd_addr);
    end
    @(negedge clk);
    n_tests++;
    if (feat_rd_addr !== 4'd1 || mm_feature_valid !== 1'b1 || mm_feature !== mem[0]) begin
      n_fail++;
      $display("FAIL rstmid_restart_beat: addr=%0d valid=%b data=%h expected 1 1 %h",
               feat_rd_addr, mm_feature_valid, mm_feature, mem[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_CELLS; i++) mem[i] = 8'(i * 13 + 5);
    rst_n           = 1'b0;
    enable          = 1'b0;
    period_cycles   = 24'd0;
    trigger         = 1'b0;
    min_score       = '0;
    min_margin      = '0;
    mm_result_valid = 1'b0;
    mm_best_class   = '0;
    mm_scores_flat  = '0;
    @(negedge clk);
    test_reset();
    test_basic_run();
    test_decision();
    test_class_switch();
    test_timeout();
    test_back_to_back();
    test_periodic();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
